// File: rtl/calc_main_if.sv
// Button and display bundle for calc_main: nine push-buttons in, seven-segment
// drive and the four BCD entry registers out.
interface calc_main_if;
  logic       B1, B2, B3, B4, B5, B6, B7, B8, B9;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] anode;
  logic [3:0] digit1, digit2, digit3, digit4;

  modport master (
    output B1, B2, B3, B4, B5, B6, B7, B8, B9,
    input  seg, dp, anode, digit1, digit2, digit3, digit4
  );

  modport slave (
    input  B1, B2, B3, B4, B5, B6, B7, B8, B9,
    output seg, dp, anode, digit1, digit2, digit3, digit4
  );
endinterface

// File: rtl/calc_main.sv
// Two-operand BCD calculator with a multiplexed active-low 4-digit display.
// Optional macro DIV_ZERO_ERR_EN: divide by zero shows dashes instead of 0000.
module calc_main #(
  parameter int REFRESH_BITS = 17,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  calc_main_if.slave  bus
);

  typedef enum logic {ENTRY, RESULT} mode_t;

  logic [8:0]              w_btn;
  logic [8:0]              r_sync [SYNC_STAGES];
  logic [8:0]              r_prev;
  logic [8:0]              w_pulse;
  logic [3:0]              r_d1, r_d2, r_d3, r_d4;
  mode_t                   r_mode;
  logic [13:0]             r_result;
  logic                    r_neg;
  logic                    r_err;
  logic [REFRESH_BITS-1:0] r_refresh;

  logic [6:0]  w_d1x, w_d3x, w_a, w_b, w_mag;
  logic        w_op_any, w_op_neg, w_op_err;
  logic [13:0] w_op_res;
  logic [1:0]  w_sel;
  logic [15:0] w_value;
  logic [3:0]  w_nib;

  function automatic logic [3:0] inc10(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Shift-and-add-3 conversion; 14 bits covers the largest product 9801.
  function automatic logic [15:0] bin2bcd(input logic [13:0] bin);
    logic [29:0] s;
    s = {16'd0, bin};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (s[14+4*d +: 4] >= 4'd5) s[14+4*d +: 4] = s[14+4*d +: 4] + 4'd3;
      end
      s = s << 1;
    end
    return s[29:14];
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign w_btn = {bus.B9, bus.B8, bus.B7, bus.B6, bus.B5,
                  bus.B4, bus.B3, bus.B2, bus.B1};

  // Synchroniser chain carries no reset so a button held across reset stays
  // high; r_prev resets to all-ones so such a button cannot fire afterwards.
  always_ff @(posedge clk_in) begin
    r_sync[0] <= w_btn;
    for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
  end

  always_ff @(posedge clk_in) begin
    if (reset) r_prev <= '1;
    else       r_prev <= r_sync[SYNC_STAGES-1];
  end

  assign w_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

  assign w_d1x = {3'd0, r_d1};
  assign w_d3x = {3'd0, r_d3};
  assign w_a   = (w_d1x << 3) + (w_d1x << 1) + {3'd0, r_d2};
  assign w_b   = (w_d3x << 3) + (w_d3x << 1) + {3'd0, r_d4};
  assign w_mag = (w_a < w_b) ? (w_b - w_a) : (w_a - w_b);

  // Operation select: B5 > B6 > B7 > B8, always from the current digits.
  always_comb begin
    w_op_any = |w_pulse[7:4];
    w_op_res = '0;
    w_op_neg = 1'b0;
    w_op_err = 1'b0;
    if (w_pulse[4]) begin
      w_op_res = {7'd0, w_a} + {7'd0, w_b};
    end else if (w_pulse[5]) begin
      w_op_res = {7'd0, w_mag};
      w_op_neg = (w_a < w_b);
    end else if (w_pulse[6]) begin
      w_op_res = {7'd0, w_a} * {7'd0, w_b};
    end else if (w_pulse[7]) begin
      if (w_b == 7'd0) begin
`ifdef DIV_ZERO_ERR_EN
        w_op_err = 1'b1;
`else
        w_op_err = 1'b0;
`endif
      end else begin
        w_op_res = {7'd0, w_a / w_b};
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_d1 <= '0; r_d2 <= '0; r_d3 <= '0; r_d4 <= '0;
      r_mode   <= ENTRY;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_pulse[8]) begin
      r_d1 <= '0; r_d2 <= '0; r_d3 <= '0; r_d4 <= '0;
      r_mode <= ENTRY;
      r_neg  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_pulse[0]) r_d1 <= inc10(r_d1);
      if (w_pulse[1]) r_d2 <= inc10(r_d2);
      if (w_pulse[2]) r_d3 <= inc10(r_d3);
      if (w_pulse[3]) r_d4 <= inc10(r_d4);
      if (w_op_any) begin
        r_mode   <= RESULT;
        r_result <= w_op_res;
        r_neg    <= w_op_neg;
        r_err    <= w_op_err;
      end else if (|w_pulse[3:0]) begin
        r_mode <= ENTRY;
        r_neg  <= 1'b0;
        r_err  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) r_refresh <= '0;
    else       r_refresh <= r_refresh + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
  end

  assign w_sel   = r_refresh[REFRESH_BITS-1 -: 2];
  assign w_value = (r_mode == RESULT) ? bin2bcd(r_result) : {r_d1, r_d2, r_d3, r_d4};

  always_comb begin
    case (w_sel)
      2'd0:    begin w_nib = w_value[15:12]; bus.anode = 4'b0111; end
      2'd1:    begin w_nib = w_value[11:8];  bus.anode = 4'b1011; end
      2'd2:    begin w_nib = w_value[7:4];   bus.anode = 4'b1101; end
      default: begin w_nib = w_value[3:0];   bus.anode = 4'b1110; end
    endcase
  end

  assign bus.seg    = r_err ? 7'b0111111 : seg7(w_nib);
  assign bus.dp     = ~((w_sel == 2'd0) && (r_mode == RESULT) && r_neg);
  assign bus.digit1 = r_d1;
  assign bus.digit2 = r_d2;
  assign bus.digit3 = r_d3;
  assign bus.digit4 = r_d4;

endmodule

// File: tb/tb_calc_main.sv
// Directed-vector bench for calc_main with a 4-bit refresh counter.
module tb_calc_main;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] btn = '0;
  int         checks = 0;
  int         errors = 0;

  calc_main_if u_if();

  assign u_if.B1 = btn[0];
  assign u_if.B2 = btn[1];
  assign u_if.B3 = btn[2];
  assign u_if.B4 = btn[3];
  assign u_if.B5 = btn[4];
  assign u_if.B6 = btn[5];
  assign u_if.B7 = btn[6];
  assign u_if.B8 = btn[7];
  assign u_if.B9 = btn[8];

  calc_main #(.REFRESH_BITS(4), .SYNC_STAGES(2)) dut (
    .clk_in (clk),
    .reset  (rst),
    .bus    (u_if.slave)
  );

  always #5 clk = ~clk;

  localparam logic [27:0] DASH4 = {4{7'b0111111}};

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'b1000000;
      4'd1: enc = 7'b1111001;
      4'd2: enc = 7'b0100100;
      4'd3: enc = 7'b0110000;
      4'd4: enc = 7'b0011001;
      4'd5: enc = 7'b0010010;
      4'd6: enc = 7'b0000010;
      4'd7: enc = 7'b1111000;
      4'd8: enc = 7'b0000000;
      4'd9: enc = 7'b0010000;
      default: enc = 7'h7F;
    endcase
  endfunction

  function automatic logic [27:0] enc4(input logic [15:0] b);
    return {enc(b[15:12]), enc(b[11:8]), enc(b[7:4]), enc(b[3:0])};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mask(input logic [8:0] m);
    btn = m;
    tick(2);
    btn = '0;
    tick(4);
  endtask

  task automatic press(input int idx, input int n);
    for (int k = 0; k < n; k++) press_mask(9'(1) << idx);
  endtask

  // One full refresh sweep: segments per digit position, dp seen on the leftmost.
  task automatic capture(output logic [27:0] segs, output logic dpl);
    segs = '0;
    dpl  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      case (u_if.anode)
        4'b0111: begin segs[27:21] = u_if.seg; dpl = u_if.dp; end
        4'b1011: segs[20:14] = u_if.seg;
        4'b1101: segs[13:7]  = u_if.seg;
        4'b1110: segs[6:0]   = u_if.seg;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(4);
    checks++;
    if (u_if.anode !== 4'b0111) begin errors++; $display("FAIL reset_anode got=%b exp=0111", u_if.anode); end
    checks++;
    if (u_if.seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg got=%b exp=1000000", u_if.seg); end
    checks++;
    if (u_if.dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", u_if.dp); end
    checks++;
    if ({u_if.digit1, u_if.digit2, u_if.digit3, u_if.digit4} !== 16'h0000) begin
      errors++; $display("FAIL reset_digits got=%h exp=0000", {u_if.digit1, u_if.digit2, u_if.digit3, u_if.digit4});
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_entry_mul();
    logic [27:0] s; logic d;
    press(0, 5);
    checks++;
    if (u_if.digit1 !== 4'd5) begin errors++; $display("FAIL digit1_step got=%0d exp=5", u_if.digit1); end
    press(0, 4); press(1, 9); press(2, 9); press(3, 9);
    checks++;
    if ({u_if.digit1, u_if.digit2, u_if.digit3, u_if.digit4} !== 16'h9999) begin
      errors++; $display("FAIL digits_9999 got=%h exp=9999", {u_if.digit1, u_if.digit2, u_if.digit3, u_if.digit4});
    end
    capture(s, d);
    checks++;
    if (s !== enc4(16'h9999)) begin errors++; $display("FAIL entry_disp got=%h exp=%h", s, enc4(16'h9999)); end
    press(6, 1);
    capture(s, d);
    checks++;
    if (s !== enc4(16'h9801) || d !== 1'b1) begin
      errors++; $display("FAIL mul_9801 got=%h dp=%b exp=%h dp=1", s, d, enc4(16'h9801));
    end
  endtask

  task automatic test_ops99();
    logic [27:0] s; logic d;
    press(4, 1); capture(s, d);
    checks++;
    if (s !== enc4(16'h0198)) begin errors++; $display("FAIL add_0198 got=%h exp=%h", s, enc4(16'h0198)); end
    press(5, 1); capture(s, d);
    checks++;
    if (s !== enc4(16'h0000) || d !== 1'b1) begin
      errors++; $display("FAIL sub_0000 got=%h dp=%b exp=%h dp=1", s, d, enc4(16'h0000));
    end
    press(7, 1); capture(s, d);
    checks++;
    if (s !== enc4(16'h0001)) begin errors++; $display("FAIL div_0001 got=%h exp=%h", s, enc4(16'h0001)); end
    checks++;
    if ({u_if.digit1, u_if.digit2, u_if.digit3, u_if.digit4} !== 16'h9999) begin
      errors++; $display("FAIL digits_kept got=%h exp=9999", {u_if.digit1, u_if.digit2, u_if.digit3, u_if.digit4});
    end
    press(8, 1); capture(s, d);
    checks++;
    if ({u_if.digit1, u_if.digit2, u_if.digit3, u_if.digit4} !== 16'h0000 || s !== enc4(16'h0000)) begin
      errors++; $display("FAIL clear got=%h disp=%h exp=0000", {u_if.digit1, u_if.digit2, u_if.digit3, u_if.digit4}, s);
    end
  endtask

  task automatic test_negative();
    logic [27:0] s; logic d;
    press(3, 9);
    press(5, 1); capture(s, d);
    checks++;
    if (s !== enc4(16'h0009) || d !== 1'b0) begin
      errors++; $display("FAIL sub_neg got=%h dp=%b exp=%h dp=0", s, d, enc4(16'h0009));
    end
    press(7, 1); capture(s, d);
    checks++;
    if (s !== enc4(16'h0000) || d !== 1'b1) begin
      errors++; $display("FAIL div_0_9 got=%h dp=%b exp=%h dp=1", s, d, enc4(16'h0000));
    end
    press(3, 1); capture(s, d);
    checks++;
    if (u_if.digit4 !== 4'd0 || s !== enc4(16'h0000)) begin
      errors++; $display("FAIL wrap9 got=%0d disp=%h exp=0", u_if.digit4, s);
    end
  endtask

  task automatic test_div0();
    logic [27:0] s; logic d; logic [27:0] exp_div;
    press(8, 1);
    press(0, 4); press(1, 3);
    press(5, 1); capture(s, d);
    checks++;
    if (s !== enc4(16'h0043) || d !== 1'b1) begin
      errors++; $display("FAIL sub_0043 got=%h dp=%b exp=%h dp=1", s, d, enc4(16'h0043));
    end
`ifdef DIV_ZERO_ERR_EN
    exp_div = DASH4;
`else
    exp_div = enc4(16'h0000);
`endif
    press(7, 1); capture(s, d);
    checks++;
    if (s !== exp_div) begin errors++; $display("FAIL div_by_zero got=%h exp=%h", s, exp_div); end
    press(6, 1); capture(s, d);
    checks++;
    if (s !== enc4(16'h0000)) begin errors++; $display("FAIL mul_after_div0 got=%h exp=%h", s, enc4(16'h0000)); end
  endtask

  task automatic test_priority();
    logic [27:0] s; logic d;
    press(8, 1);
    press(0, 2); press(3, 5);
    press_mask(9'b000110001);
    capture(s, d);
    checks++;
    if (s !== enc4(16'h0025) || u_if.digit1 !== 4'd3) begin
      errors++; $display("FAIL prio_add got=%h d1=%0d exp=%h d1=3", s, u_if.digit1, enc4(16'h0025));
    end
    press_mask(9'b100100000);
    capture(s, d);
    checks++;
    if ({u_if.digit1, u_if.digit2, u_if.digit3, u_if.digit4} !== 16'h0000 || s !== enc4(16'h0000)) begin
      errors++; $display("FAIL prio_clear got=%h disp=%h exp=0000", {u_if.digit1, u_if.digit2, u_if.digit3, u_if.digit4}, s);
    end
  endtask

  task automatic test_hold();
    logic [27:0] s; logic d;
    press(2, 2); press(3, 2);
    press(7, 1); capture(s, d);
    checks++;
    if (s !== enc4(16'h0000)) begin errors++; $display("FAIL div_0_22 got=%h exp=%h", s, enc4(16'h0000)); end
    press(8, 1);
    btn[0] = 1'b1; tick(20); btn[0] = 1'b0; tick(4);
    checks++;
    if (u_if.digit1 !== 4'd1) begin errors++; $display("FAIL hold_once got=%0d exp=1", u_if.digit1); end
  endtask

  task automatic test_reset_hold();
    btn[1] = 1'b1; tick(6);
    rst = 1'b1; tick(2); rst = 1'b0;
    tick(6); btn[1] = 1'b0; tick(6);
    checks++;
    if ({u_if.digit1, u_if.digit2, u_if.digit3, u_if.digit4} !== 16'h0000) begin
      errors++; $display("FAIL reset_hold got=%h exp=0000", {u_if.digit1, u_if.digit2, u_if.digit3, u_if.digit4});
    end
  endtask

  initial begin
    test_reset();
    test_entry_mul();
    test_ops99();
    test_negative();
    test_div0();
    test_priority();
    test_hold();
    test_reset_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_main.md
Name: calc_main

Overview:
- Two-operand decimal calculator top level for a 4-digit seven-segment board.
- Four push-buttons each step one BCD digit. The digits form operand A (digit1 tens, digit2 units) and operand B (digit3 tens, digit4 units).
- Four buttons select add, subtract, multiply and divide; one button clears.
- The entry or result value is shown on a time-multiplexed, active-low 4-digit display.

Parameters:
- REFRESH_BITS, 17, width of the display refresh counter. The top 2 bits select the active digit. Benches use 4.
- SYNC_STAGES, 2, number of flip-flop stages in each button synchroniser.

Ports:
- clk_in  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- B1  input  1  increment digit1 (operand A tens)
- B2  input  1  increment digit2 (operand A units)
- B3  input  1  increment digit3 (operand B tens)
- B4  input  1  increment digit4 (operand B units)
- B5  input  1  add, A+B
- B6  input  1  subtract, A-B
- B7  input  1  multiply, A*B
- B8  input  1  divide, integer A/B
- B9  input  1  clear
- seg  output  7  cathodes, active-low; seg[0]=a ... seg[6]=g
- dp  output  1  decimal point, active-low; used as the negative-sign indicator
- anode  output  4  digit enables, active-low; anode[3]=leftmost (digit1) ... anode[0]=rightmost
- digit1..digit4  output  4 each  current BCD entry registers

Behaviour:
- Reset (synchronous, active-high):
  - digit1..4 = 0; mode = ENTRY; result = 0; neg = 0; err = 0.
  - Refresh counter = 0, so anode = 4'b0111, seg = 7'b1000000 ("0"), dp = 1.
- Button conditioning:
  - Each button passes through a SYNC_STAGES synchroniser, then a rising-edge detector (one-cycle pulse per press).
  - Held buttons act once; there is no auto-repeat.
  - Press to action latency is SYNC_STAGES+1 cycles.
- B1-B4 pulse:
  - Increments the matching digit modulo 10 (9 wraps to 0).
  - Sets mode = ENTRY and clears neg and err.
- Operand values: A = 10*digit1 + digit2 and B = 10*digit3 + digit4, unsigned, 0..99.
- Operation pulse (B5-B8):
  - Computes from the pre-edge digit values, registers the result one cycle later and sets mode = RESULT.
  - Digit registers are unchanged.
  - ADD: 0..198.
  - SUB: magnitude |A-B| with neg = (A<B).
  - MUL: 0..9801.
  - DIV: floor(A/B). B=0 gives a divide-by-zero result (see Optional Feature).
- B9 pulse: digits cleared to 0, mode = ENTRY, neg = err = 0.
- Priority on simultaneous pulses:
  - B9 beats everything.
  - Among operations: B5 > B6 > B7 > B8.
  - Digit pulses coincident with an operation still increment, but the operation uses the old values and mode ends in RESULT.
- Display value:
  - ENTRY mode shows digit1..digit4.
  - RESULT mode shows the result converted to 4 BCD digits (binary-to-BCD, e.g. double-dabble), with leading zeros shown.
- Multiplexing:
  - Counter top bits 00/01/10/11 select anode 0111/1011/1101/1110 = thousands/hundreds/tens/units.
  - Segment encoding is standard active-low hex-0..9; codes 10-15 blank (7'h7F).
- dp: 0 only while anode[3] is active and mode = RESULT and neg = 1; otherwise 1.
- Reset mid-operation: a reset in the same cycle as any pulse wins.

Optional Feature:
- Macro DIV_ZERO_ERR_EN.
- When defined: divide with B=0 sets err = 1 and all four digits show a dash (seg = 7'b0111111) until the next digit, operation or clear pulse.
- When not defined: divide with B=0 yields result 0, neg = 0, and no error indication.

Test Plan:
- Reset, then 9 presses each of B1..B4: digits wrap 1..9, end at 9,9,9,9. B7: display 9801, dp=1.
- From 99/99: B5 gives 0198; B6 gives 0000 with dp=1; B8 gives 0001; B9 gives digits 0000, ENTRY mode.
- After clear, 9 presses of B4 (A=0, B=9): B6 gives 0009 with dp=0 on the leftmost digit; B8 gives 0000.
- A=43, B=0 (B1 x4, B2 x3): B6 gives 0043; B8 gives dashes with DIV_ZERO_ERR_EN, else 0000. B7 gives 0000 and clears err.
- A=0, B=22: B8 gives 0000. A button held for 20 cycles increments once. A reset pulse during a held button leaves all digits 0.
